// File: rtl/mcu_spi_slave.sv
// SPI mode 0 slave front end, oversampled in the clk domain, with a byte-strobe receive side
// and a registered MISO serialiser. Optional frame-abort timeout enabled by MCU_SPI_TIMEOUT_EN.
module mcu_spi_slave #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_csn,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       rx_strobe,
    output logic       rx_start,
    output logic [7:0] rx_byte,
    input  logic [7:0] tx_byte,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT} state_e;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] csn_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   csn_s, sclk_s, mosi_s, sclk_rise, sclk_fall, tmo_hit;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [6:0]             rx_shift_q, rx_shift_d;     // first seven bits of the byte in flight
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [7:0]             rx_byte_q, rx_byte_d;
    logic                   first_flag_q, first_flag_d;
    logic                   rx_strobe_q, rx_strobe_d;
    logic                   rx_start_q, rx_start_d;

    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

`ifdef MCU_SPI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q;

    // Counts clk cycles since the last SCLK edge while a frame is open.
    assign tmo_hit = (state_q == SHIFT) && !csn_s && !sclk_rise && !sclk_fall &&
                     (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == SHIFT && !sclk_rise && !sclk_fall && !tmo_hit)
            tmo_cnt_d = tmo_cnt_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= tmo_hit;
        end
    end

    assign timeout = timeout_q;
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        rx_byte_d    = rx_byte_q;
        first_flag_d = first_flag_q;
        rx_strobe_d  = 1'b0;
        rx_start_d   = 1'b0;
        case (state_q)
            WAIT_HI: if (csn_s) state_d = IDLE;
            IDLE: begin
                if (!csn_s) begin
                    state_d      = SHIFT;
                    bitcnt_d     = 3'd0;
                    first_flag_d = 1'b1;
                    tx_shift_d   = 8'h00;
                end
            end
            SHIFT: begin
                // Chip-select release takes priority over any SCLK edge seen in the same cycle.
                if (csn_s) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    state_d    = WAIT_HI;
                    tx_shift_d = 8'h00;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[5:0], mosi_s};
                        bitcnt_d   = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            rx_byte_d    = {rx_shift_q, mosi_s};
                            rx_strobe_d  = 1'b1;
                            rx_start_d   = first_flag_q;
                            first_flag_d = 1'b0;
                        end
                    end
                    if (sclk_fall) begin
                        if (bitcnt_q == 3'd0) tx_shift_d = tx_byte;
                        else                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            // csn synchroniser clears to "selected": after reset a still-open frame is ignored until csn rises.
            csn_sync_q   <= '0;
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            state_q      <= WAIT_HI;
            bitcnt_q     <= 3'd0;
            rx_shift_q   <= 7'd0;
            tx_shift_q   <= 8'h00;
            rx_byte_q    <= 8'h00;
            first_flag_q <= 1'b0;
            rx_strobe_q  <= 1'b0;
            rx_start_q   <= 1'b0;
        end else begin
            csn_sync_q   <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q  <= sclk_s;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            rx_byte_q    <= rx_byte_d;
            first_flag_q <= first_flag_d;
            rx_strobe_q  <= rx_strobe_d;
            rx_start_q   <= rx_start_d;
        end
    end

    // MISO is the MSB of the transmit shift register, so it is already a clk-domain flop.
    assign spi_miso  = tx_shift_q[7];
    assign rx_strobe = rx_strobe_q;
    assign rx_start  = rx_start_q;
    assign rx_byte   = rx_byte_q;
    assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Self-checking bench for mcu_spi_slave: SPI master model, reply model (rx_byte+1, 1 clk lag),
// vector table of frames, hand-written corner sequences and a random 32-byte frame.
module tb_mcu_spi_slave;
    localparam int SYNC = 2;
    localparam int TMO  = 64;
    localparam int HP   = 4;   // SCLK half period in clk cycles (SCLK = clk/8)

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_csn = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
    logic       spi_miso, rx_strobe, rx_start, busy, timeout;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte = 8'h00;

    mcu_spi_slave #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .rx_strobe(rx_strobe), .rx_start(rx_start), .rx_byte(rx_byte),
        .tx_byte(tx_byte), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Downstream control block: replies with received byte + 1, registered one clk later.
    always @(posedge clk) tx_byte <= rx_byte + 8'd1;

    typedef struct packed {
        int              nbytes;
        logic [0:2][7:0] mosi;
        logic [0:2][7:0] exp_miso;
    } vec_t;

    int         checks = 0, failures = 0;
    logic [8:0] rx_q[$];
    int         tmo_pulses = 0, bad_strobes = 0;
    logic [7:0] frame_bytes [64];
    logic [7:0] miso_bytes  [64];

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_strobe) rx_q.push_back({rx_start, rx_byte});
            if (rx_strobe && !busy) bad_strobes <= bad_strobes + 1;
            if (timeout) tmo_pulses <= tmo_pulses + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Shift nbits of b (MSB first) in mode 0; MISO is sampled just before each rising edge.
    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            repeat (HP) @(negedge clk);
            got = {got[6:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (HP) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic end_frame();
        repeat (HP) @(negedge clk);
        spi_csn = 1'b1;
        repeat (SYNC + 4) @(negedge clk);
    endtask

    task automatic run_frame(input int n);
        logic [7:0] g;
        spi_csn = 1'b0;
        for (int k = 0; k < n; k++) begin
            spi_bits(frame_bytes[k], 8, g);
            miso_bytes[k] = g;
        end
        end_frame();
    endtask

    // Compare collected strobes with the first n bytes of frame_bytes; only the first is a start.
    task automatic check_strobes(input string tag, input int n);
        check($sformatf("%s strobe_count", tag), rx_q.size(), n);
        for (int k = 0; k < n && k < rx_q.size(); k++)
            check($sformatf("%s rx%0d", tag, k), {23'd0, rx_q[k]}, {23'd0, k == 0, frame_bytes[k]});
        rx_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [3];
        logic [7:0] g, exp8;
        int         t0;

        vecs[0] = '{nbytes: 2, mosi: {8'h00, 8'hAA, 8'h00}, exp_miso: {8'h00, 8'h01, 8'h00}};
        vecs[1] = '{nbytes: 3, mosi: {8'h01, 8'h02, 8'h03}, exp_miso: {8'h00, 8'h02, 8'h03}};
        vecs[2] = '{nbytes: 3, mosi: {8'hFF, 8'h7E, 8'h80}, exp_miso: {8'h00, 8'h00, 8'h7F}};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset spi_miso", spi_miso, 0);
        check("reset rx_strobe", rx_strobe, 0);
        check("reset rx_start", rx_start, 0);
        check("reset rx_byte", rx_byte, 0);
        check("reset busy", busy, 0);
        check("reset timeout", timeout, 0);
        repeat (SYNC + 4) @(negedge clk);

        // Table-driven frames: received bytes, start flag and MISO reply lag.
        for (int v = 0; v < 3; v++) begin
            for (int k = 0; k < vecs[v].nbytes; k++) frame_bytes[k] = vecs[v].mosi[k];
            run_frame(vecs[v].nbytes);
            check_strobes($sformatf("vec%0d", v), vecs[v].nbytes);
            for (int k = 0; k < vecs[v].nbytes; k++)
                check($sformatf("vec%0d miso%0d", v, k), miso_bytes[k], vecs[v].exp_miso[k]);
            check($sformatf("vec%0d busy_after", v), busy, 0);
        end

        // Partial byte cut by csn, then a fresh one-byte frame.
        spi_csn = 1'b0;
        spi_bits(8'hE7, 5, g);
        end_frame();
        check("partial no_strobe", rx_q.size(), 0);
        frame_bytes[0] = 8'h5C;
        run_frame(1);
        check_strobes("after_partial", 1);

        // csn release in the same cycle as the 8th rising edge: the edge is ignored.
        spi_csn = 1'b0;
        spi_bits(8'h3C, 8, g);
        spi_bits(8'h96, 7, g);
        spi_mosi = 1'b0;
        repeat (HP) @(negedge clk);
        spi_sclk = 1'b1;
        spi_csn  = 1'b1;
        repeat (HP) @(negedge clk);
        spi_sclk = 1'b0;
        repeat (SYNC + 4) @(negedge clk);
        frame_bytes[0] = 8'h3C;
        check_strobes("csn_vs_edge", 1);

        // Reset mid-frame with csn held low: nothing is strobed until a new frame.
        spi_csn = 1'b0;
        spi_bits(8'h11, 8, g);
        spi_bits(8'h22, 4, g);
        frame_bytes[0] = 8'h11;
        check_strobes("pre_reset", 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        spi_bits(8'hA5, 8, g);
        spi_bits(8'h5A, 8, g);
        check("reset_midframe no_strobe", rx_q.size(), 0);
        check("reset_midframe busy", busy, 0);
        end_frame();
        frame_bytes[0] = 8'h33;
        run_frame(1);
        check_strobes("after_reset", 1);

        // SCLK stalls after 3 bits.
        t0 = tmo_pulses;
        spi_csn = 1'b0;
        spi_bits(8'hC3, 3, g);
        repeat (TMO + 40) @(negedge clk);
`ifdef MCU_SPI_TIMEOUT_EN
        check("timeout pulses", tmo_pulses - t0, 1);
        check("timeout busy", busy, 0);
        check("timeout miso", spi_miso, 0);
`else
        check("no_timeout pulses", tmo_pulses - t0, 0);
        check("no_timeout busy", busy, 1);
`endif
        check("stall no_strobe", rx_q.size(), 0);
        end_frame();
        frame_bytes[0] = 8'h9D;
        frame_bytes[1] = 8'h42;
        run_frame(2);
        check_strobes("after_stall", 2);

        // 32 random bytes: in-order reception and reply in the following slot.
        for (int k = 0; k < 32; k++) frame_bytes[k] = 8'($urandom_range(0, 255));
        run_frame(32);
        check_strobes("random", 32);
        for (int k = 0; k < 32; k++) begin
            exp8 = (k == 0) ? 8'h00 : frame_bytes[k-1] + 8'd1;
            check($sformatf("random miso%0d", k), miso_bytes[k], exp8);
        end

        check("strobe_outside_frame", bad_strobes, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
